zeroriscy_rf_wb_arbiter: RTL

ZERORISCY_RF_WB_ARBITER -- requirements
Module: zeroriscy_rf_wb_arbiter

---
 rtl/zeroriscy_wb_pkg.sv | 34 +++
 rtl/zeroriscy_wb_fifo.sv | 71 +++++++
 rtl/zeroriscy_rf_wb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/zeroriscy_wb_pkg.sv
// Shared types for the register-file writeback arbiter: pending-entry layout,
// occupancy states and the RV32E-aware address helpers.
package zeroriscy_wb_pkg;

  localparam int WB_MAX_DW = 64;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [WB_MAX_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PEND,
    OCC_FULL
  } occ_state_e;

  // RV32E only decodes 16 registers, so bit 4 is ignored in every comparison.
  function automatic logic addrMatch(input logic [4:0] a, input logic [4:0] b,
                                     input logic rv32e);
    logic [4:0] mask;
    mask = rv32e ? 5'h0F : 5'h1F;
    return ((a ^ b) & mask) == 5'd0;
  endfunction

  function automatic logic addrIsZero(input logic [4:0] a, input logic rv32e);
    logic [4:0] mask;
    mask = rv32e ? 5'h0F : 5'h1F;
    return (a & mask) == 5'd0;
  endfunction

endpackage

// File: rtl/zeroriscy_wb_fifo.sv
// In-order pending-load buffer: storage, wrapping pointers, occupancy count and
// per-entry invalidation by newer EX writes.
module zeroriscy_wb_fifo
  import zeroriscy_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RV32E = 0,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_int,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  inv_i,
  input  logic [4:0]            inv_addr_i,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic [PTR_W-1:0]      rd_ptr_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam logic RV32E_L = (RV32E != 0);

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_doPush = push_i && (r_count != CNT_W'(DEPTH));
  assign w_doPop  = pop_i && (r_count != '0);

  // Popped slots are cleared so that "valid" alone marks live, uninvalidated data.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
    end else begin
      if (inv_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_entries[i].valid && addrMatch(r_entries[i].addr, inv_addr_i, RV32E_L))
            r_entries[i].valid <= 1'b0;
        end
      end
      if (w_doPop) begin
        r_entries[r_rdPtr].valid <= 1'b0;
        r_rdPtr                  <= nextPtr(r_rdPtr);
      end
      if (w_doPush) begin
        r_entries[r_wrPtr] <= push_entry_i;
        r_wrPtr            <= nextPtr(r_wrPtr);
      end
      if (w_doPush && !w_doPop)
        r_count <= r_count + CNT_W'(1);
      else if (w_doPop && !w_doPush)
        r_count <= r_count - CNT_W'(1);
    end
  end

  assign entries_o = r_entries;
  assign rd_ptr_o  = r_rdPtr;
  assign count_o   = r_count;

endmodule

// File: rtl/zeroriscy_rf_wb_arbiter.sv
// Arbitrates EX and LSU writebacks onto one register-file write port.
// Define ZERORISCY_WB_FWD_EN to forward pending load data instead of stalling decode.
module zeroriscy_rf_wb_arbiter
  import zeroriscy_wb_pkg::*;
#(
  parameter int RV32E      = 0,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_int,
  input  logic                  rst_n,
  input  logic                  ex_we_i,
  input  logic [4:0]            ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_valid_i,
  input  logic [4:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic                  hazard_o,
  output logic [2:0]            pend_cnt_o
);

  localparam int   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic RV32E_L = (RV32E != 0);

  wb_entry_t [DEPTH-1:0] w_entries;
  wb_entry_t             w_head;
  wb_entry_t             w_pushEntry;
  logic [PTR_W-1:0]      w_rdPtr;
  logic [CNT_W-1:0]      w_count;
  occ_state_e            w_state;
  logic                  w_lsuAccept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_inv;
  logic                  w_unused;

  always_comb begin
    w_state = OCC_PEND;
    if (w_count == '0)
      w_state = OCC_EMPTY;
    else if (w_count == CNT_W'(DEPTH))
      w_state = OCC_FULL;
  end

  assign lsu_ready_o = (w_state != OCC_FULL);
  assign pend_cnt_o  = w_count;
  assign w_head      = w_entries[w_rdPtr];
  assign w_unused    = ^w_entries;

  // A load racing a same-address EX write is the older value and is dropped.
  assign w_lsuAccept = lsu_valid_i && lsu_ready_o;
  assign w_bypass    = w_lsuAccept && !ex_we_i && (w_state == OCC_EMPTY);
  assign w_push      = w_lsuAccept && !w_bypass && !addrIsZero(lsu_waddr_i, RV32E_L) &&
                       !(ex_we_i && addrMatch(ex_waddr_i, lsu_waddr_i, RV32E_L));
  assign w_pop       = !ex_we_i && (w_state != OCC_EMPTY);
  assign w_inv       = ex_we_i && !addrIsZero(ex_waddr_i, RV32E_L);

  always_comb begin
    w_pushEntry       = '0;
    w_pushEntry.valid = 1'b1;
    w_pushEntry.addr  = lsu_waddr_i;
    w_pushEntry.data  = WB_MAX_DW'(lsu_wdata_i);
  end

  zeroriscy_wb_fifo #(
    .DEPTH (DEPTH),
    .RV32E (RV32E)
  ) u_fifo (
    .clk_int      (clk_int),
    .rst_n        (rst_n),
    .push_i       (w_push),
    .push_entry_i (w_pushEntry),
    .pop_i        (w_pop),
    .inv_i        (w_inv),
    .inv_addr_i   (ex_waddr_i),
    .entries_o    (w_entries),
    .rd_ptr_o     (w_rdPtr),
    .count_o      (w_count)
  );

  // Priority: EX, then buffer head (invalidated heads pop silently), then bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = ex_waddr_i;
    rf_wdata_o = ex_wdata_i;
    if (ex_we_i) begin
      rf_we_o = !addrIsZero(ex_waddr_i, RV32E_L);
    end else if (w_pop) begin
      rf_we_o    = w_head.valid;
      rf_waddr_o = w_head.addr;
      rf_wdata_o = w_head.data[DATA_WIDTH-1:0];
    end else if (w_bypass) begin
      rf_we_o    = !addrIsZero(lsu_waddr_i, RV32E_L);
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end
    if (!rst_n)
      rf_we_o = 1'b0;
  end

`ifdef ZERORISCY_WB_FWD_EN
  // Walk from oldest to newest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    rdata_a_o = rf_rdata_a_i;
    rdata_b_o = rf_rdata_b_i;
    hazard_o  = 1'b0;
    slot      = w_rdPtr;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_entries[slot].valid && !addrIsZero(raddr_a_i, RV32E_L) &&
          addrMatch(w_entries[slot].addr, raddr_a_i, RV32E_L))
        rdata_a_o = w_entries[slot].data[DATA_WIDTH-1:0];
      if (w_entries[slot].valid && !addrIsZero(raddr_b_i, RV32E_L) &&
          addrMatch(w_entries[slot].addr, raddr_b_i, RV32E_L))
        rdata_b_o = w_entries[slot].data[DATA_WIDTH-1:0];
      slot = (slot == PTR_W'(DEPTH - 1)) ? '0 : slot + PTR_W'(1);
    end
  end
`else
  always_comb begin
    rdata_a_o = rf_rdata_a_i;
    rdata_b_o = rf_rdata_b_i;
    hazard_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entries[i].valid &&
          ((!addrIsZero(raddr_a_i, RV32E_L) && addrMatch(w_entries[i].addr, raddr_a_i, RV32E_L)) ||
           (!addrIsZero(raddr_b_i, RV32E_L) && addrMatch(w_entries[i].addr, raddr_b_i, RV32E_L))))
        hazard_o = 1'b1;
    end
    if (!rst_n)
      hazard_o = 1'b0;
  end
`endif

endmodule
